// File: rtl/chaser_sequencer.sv
// LED chaser sequencer: latches a mode/delay/pass-count command and steps the
// LED pattern until the requested passes finish or the host aborts.
module chaser_sequencer #(
  parameter int NUM_LEDS = 5,
  parameter int DELAY_W  = 8,
  parameter int REP_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [DELAY_W-1:0]  cmd_delay,
  input  logic [REP_W-1:0]    cmd_repeat,
  input  logic                pause,
  input  logic                abort,
  output logic [NUM_LEDS-1:0] leds,
  output logic                busy,
  output logic                done
);
  localparam int STEP_W = $clog2(2 * NUM_LEDS) + 1;

  localparam logic [1:0] MODE_LEFT   = 2'b00;
  localparam logic [1:0] MODE_RIGHT  = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_BLINK  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [1:0]          mode;
  logic [DELAY_W-1:0]  delay;
  logic [REP_W-1:0]    rep;
  logic [DELAY_W-1:0]  tick;
  logic [STEP_W-1:0]   step_cnt;
  logic [REP_W-1:0]    pass_cnt;
  logic                dir_down;

  logic [STEP_W-1:0]   pass_last;
  logic [NUM_LEDS-1:0] init_pat;
  logic [NUM_LEDS-1:0] next_pat;
  logic                next_dir;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    case (mode)
      MODE_BOUNCE: pass_last = STEP_W'(2 * NUM_LEDS - 3);
      MODE_BLINK:  pass_last = STEP_W'(1);
      default:     pass_last = STEP_W'(NUM_LEDS - 1);
    endcase
  end

  always_comb begin
    case (cmd_mode)
      MODE_RIGHT: init_pat = {1'b1, {(NUM_LEDS-1){1'b0}}};
      MODE_BLINK: init_pat = '1;
      default:    init_pat = NUM_LEDS'(1);
    endcase
  end

  // Bounce flips direction as it lands on an endpoint, so each endpoint shows once.
  always_comb begin
    next_dir = dir_down;
    case (mode)
      MODE_LEFT:  next_pat = {leds[NUM_LEDS-2:0], leds[NUM_LEDS-1]};
      MODE_RIGHT: next_pat = {leds[0], leds[NUM_LEDS-1:1]};
      MODE_BLINK: next_pat = ~leds;
      default: begin
        if (!dir_down) begin
          next_pat = leds << 1;
          if (leds[NUM_LEDS-2]) next_dir = 1'b1;
        end else begin
          next_pat = leds >> 1;
          if (leds[1]) next_dir = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mode     <= MODE_LEFT;
      delay    <= '0;
      rep      <= '0;
      tick     <= '0;
      step_cnt <= '0;
      pass_cnt <= '0;
      dir_down <= 1'b0;
      leds     <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (cmd_valid) begin
            state    <= RUN;
            mode     <= cmd_mode;
            delay    <= cmd_delay;
            rep      <= cmd_repeat;
            tick     <= '0;
            step_cnt <= '0;
            pass_cnt <= '0;
            dir_down <= 1'b0;
            leds     <= init_pat;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            leds  <= '0;
          end else if (!pause) begin
            if (tick != delay) begin
              tick <= tick + 1'b1;
            end else begin
              tick <= '0;
              if (step_cnt == pass_last) begin
                if (rep != '0 && pass_cnt == rep - REP_W'(1)) begin
                  state <= DONE;
                  leds  <= '0;
                  done  <= 1'b1;
                end else begin
                  pass_cnt <= pass_cnt + 1'b1;
                  step_cnt <= '0;
                  leds     <= next_pat;
                  dir_down <= next_dir;
                end
              end else begin
                step_cnt <= step_cnt + 1'b1;
                leds     <= next_pat;
                dir_down <= next_dir;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
